pipe_stage_elastic: RTL and testbench

//  Generic parametrised pipeline latch for the MIPS core, superseding the fixed
//  32-bit PC/instruction latches.

---
 rtl/pipe_stage_elastic.sv | 141 ++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline latch with flush-to-bubble and optional 2-entry skid buffer.
// Define PIPE_STAGE_PERF_EN to add the saturating stall_cnt/flush_cnt performance counters.
module pipe_stage_elastic #(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
  parameter bit                SKID      = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nx;
  logic [DATA_W-1:0] main_r;
  logic [DATA_W-1:0] main_nx;
  logic [DATA_W-1:0] skid_r;
  logic [DATA_W-1:0] skid_nx;
  logic              in_ready_r;
  logic              acc_s;
  logic              pop_s;

  assign out_valid = (state_r != ST_EMPTY);
  assign out_data  = main_r;
  assign occupancy = state_r;
  // Skid build keeps in_ready off the out_ready path; single-entry build forwards it.
  assign in_ready  = SKID ? in_ready_r : (~out_valid | out_ready);
  assign acc_s     = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;

  // Next-state and payload steering; flush overrides every transfer.
  always_comb begin
    state_nx = state_r;
    main_nx  = main_r;
    skid_nx  = skid_r;
    if (flush) begin
      state_nx = ST_EMPTY;
      main_nx  = NOP_VALUE;
      skid_nx  = NOP_VALUE;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (acc_s) begin
            state_nx = ST_ONE;
            main_nx  = in_data;
          end else begin
            state_nx = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (acc_s && pop_s) begin
            main_nx = in_data;
          end else if (acc_s && SKID) begin
            state_nx = ST_TWO;
            skid_nx  = in_data;
          end else if (pop_s) begin
            state_nx = ST_EMPTY;
            main_nx  = NOP_VALUE;
          end else begin
            state_nx = ST_ONE;
          end
        end
        ST_TWO: begin
          if (pop_s) begin
            state_nx = ST_ONE;
            main_nx  = skid_r;
            skid_nx  = NOP_VALUE;
          end else begin
            state_nx = ST_TWO;
          end
        end
        default: begin
          state_nx = ST_EMPTY;
          main_nx  = NOP_VALUE;
          skid_nx  = NOP_VALUE;
        end
      endcase
    end
  end

  // State, payload and registered in_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_EMPTY;
      main_r     <= NOP_VALUE;
      skid_r     <= NOP_VALUE;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_nx;
      main_r     <= main_nx;
      skid_r     <= skid_nx;
      in_ready_r <= (state_nx != ST_TWO);
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic stall_s;
  logic flush_hit_s;

  assign stall_s     = out_valid & ~out_ready;
  assign flush_hit_s = flush & (out_valid | acc_s);

  // Saturating counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (stall_s && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (flush_hit_s && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end else begin
        flush_cnt <= flush_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: skid (u_a) and single-entry (u_b) instances,
// plus a bounded random run of u_a against a queue model.
module tb_pipe_stage_elastic;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [1:0]    a_occ;
  logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [1:0]    b_occ;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   a_stall_cnt, b_stall_cnt;
  logic [15:0]   a_flush_cnt, b_flush_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.DATA_W(DW), .NOP_VALUE(8'h00), .SKID(1'b1)) u_a (
    .clk(clk), .reset(reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
`endif
  );

  pipe_stage_elastic #(.DATA_W(DW), .NOP_VALUE(8'h00), .SKID(1'b0)) u_b (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occ)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] q[$];
    logic          m_acc, m_pop;

    reset = 1'b1;
    a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b1;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = 8'h00; b_out_ready = 1'b1;

    // T1 reset
    step(); step();
    chk("rst_out_valid", a_out_valid, 32'd0);
    chk("rst_out_data", a_out_data, 32'h00);
    chk("rst_in_ready", a_in_ready, 32'd1);
    chk("rst_occ", a_occ, 32'd0);
    chk("rst_b_in_ready", b_in_ready, 32'd1);
    reset = 1'b0;

    // T2 stream 0x11..0x18, one cycle latency, no gaps
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'h11 + 8'(i);
      step();
      chk("stream_valid", a_out_valid, 32'd1);
      chk("stream_data", a_out_data, 32'h11 + 32'(i));
    end
    a_in_valid = 1'b0;
    step();
    chk("stream_drain_valid", a_out_valid, 32'd0);
    chk("stream_drain_data", a_out_data, 32'h00);

    // T3 skid fill, stall, drain in order
    a_in_valid = 1'b1; a_in_data = 8'hA0; a_out_ready = 1'b1;
    step();
    chk("skid_occ1", a_occ, 32'd1);
    a_out_ready = 1'b0; a_in_data = 8'hA1;
    step();
    chk("skid_occ2", a_occ, 32'd2);
    chk("skid_in_ready0", a_in_ready, 32'd0);
    chk("skid_head", a_out_data, 32'hA0);
    a_in_data = 8'hC7;
    step();
    chk("skid_stall_data", a_out_data, 32'hA0);
    chk("skid_stall_occ", a_occ, 32'd2);
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    step();
    chk("skid_pop1", a_out_data, 32'hA1);
    chk("skid_pop1_occ", a_occ, 32'd1);
    chk("skid_pop1_ready", a_in_ready, 32'd1);
    step();
    chk("skid_pop2_valid", a_out_valid, 32'd0);
    chk("skid_pop2_data", a_out_data, 32'h00);

    // T4 flush from TWO with in_valid, then flush from ONE with acc&pop
    a_in_valid = 1'b1; a_in_data = 8'hB3; a_out_ready = 1'b0;
    step();
    a_in_data = 8'hB4;
    step();
    chk("flush_pre_occ", a_occ, 32'd2);
    a_flush = 1'b1; a_in_data = 8'hB5;
    step();
    chk("flush_valid", a_out_valid, 32'd0);
    chk("flush_data", a_out_data, 32'h00);
    chk("flush_occ", a_occ, 32'd0);
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    step();
    chk("flush_no_b5", a_out_valid, 32'd0);
    a_in_valid = 1'b1; a_in_data = 8'hC1;
    step();
    chk("flush1_pre", a_out_data, 32'hC1);
    a_flush = 1'b1; a_in_data = 8'hC2;
    step();
    chk("flush1_valid", a_out_valid, 32'd0);
    a_flush = 1'b0; a_in_valid = 1'b0;
    step();
    chk("flush1_no_c2", a_out_valid, 32'd0);

    // T5 single-entry: combinational in_ready and replace without bubble
    b_in_valid = 1'b1; b_in_data = 8'h51; b_out_ready = 1'b1;
    step();
    chk("ns_first", b_out_data, 32'h51);
    b_out_ready = 1'b0;
    #1;
    chk("ns_ready_low", b_in_ready, 32'd0);
    b_out_ready = 1'b1;
    #1;
    chk("ns_ready_high", b_in_ready, 32'd1);
    b_in_data = 8'h52;
    step();
    chk("ns_replace_data", b_out_data, 32'h52);
    chk("ns_replace_valid", b_out_valid, 32'd1);
    b_out_ready = 1'b0; b_in_data = 8'h55;
    step();
    chk("ns_stall_hold", b_out_data, 32'h52);
    chk("ns_stall_occ", b_occ, 32'd1);
    b_out_ready = 1'b1;
    step();
    chk("ns_after_stall", b_out_data, 32'h55);
    b_in_valid = 1'b0;
    step();
    chk("ns_empty_valid", b_out_valid, 32'd0);
    chk("ns_empty_occ", b_occ, 32'd0);

`ifdef PIPE_STAGE_PERF_EN
    // T6 counters: 5 stall cycles, one discarding flush, one empty flush
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("perf_rst_stall", a_stall_cnt, 32'd0);
    a_in_valid = 1'b1; a_in_data = 8'hD0; a_out_ready = 1'b1;
    step();
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    a_flush = 1'b1; a_out_ready = 1'b1;
    step();
    step();
    a_flush = 1'b0;
    step();
    chk("perf_stall_cnt", a_stall_cnt, 32'd5);
    chk("perf_flush_cnt", a_flush_cnt, 32'd1);
`endif

    // T7 random valid/ready/flush against a queue model
    reset = 1'b1;
    step();
    reset = 1'b0;
    q.delete();
    for (int c = 0; c < 1500; c++) begin
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_in_data   = 8'($urandom);
      a_out_ready = ($urandom_range(0, 2) != 0);
      a_flush     = ($urandom_range(0, 31) == 0);
      #1;
      chk("rnd_in_ready", a_in_ready, (q.size() < 2) ? 32'd1 : 32'd0);
      m_acc = a_in_valid && (q.size() < 2);
      m_pop = a_out_ready && (q.size() > 0);
      step();
      if (a_flush) begin
        q.delete();
      end else begin
        if (m_pop) void'(q.pop_front());
        if (m_acc) q.push_back(a_in_data);
      end
      chk("rnd_valid", a_out_valid, (q.size() > 0) ? 32'd1 : 32'd0);
      chk("rnd_data", a_out_data, (q.size() > 0) ? 32'(q[0]) : 32'h00);
      chk("rnd_occ", a_occ, 32'(q.size()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
